// File: rtl/lcd_seq_pkg.sv
// rtl/lcd_seq_pkg.sv - shared tags, FSM encoding and entry width for the LCD init sequencer
package lcd_seq_pkg;

    // Entry tag field, stored above the payload in each ROM word.
    localparam logic [1:0] TAG_CMD   = 2'b00;
    localparam logic [1:0] TAG_DATA  = 2'b01;
    localparam logic [1:0] TAG_DELAY = 2'b10;
    localparam logic [1:0] TAG_END   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_SEND,
        S_WAIT,
        S_FINISH
    } seq_state_t;

    // One ROM entry is {tag[1:0], payload[data_w-1:0]}.
    function automatic int entry_w(input int data_w);
        return data_w + 2;
    endfunction

endpackage

// File: rtl/seq_rom.sv
// rtl/seq_rom.sv - synchronous-read script ROM for the LCD init sequencer
// Ports:
//   i_clk      system clock
//   i_rd_en    read strobe; o_rd_data updates on the next edge only when set
//   i_rd_addr  entry index
//   o_rd_data  registered entry {tag, payload}
// INIT_IMAGE holds entry i at bits [i*WIDTH +: WIDTH]; its all-ones default makes
// every entry an END (tag 2'b11), so entries a script does not fill stay END.
module seq_rom #(
    parameter int                       DEPTH      = 64,
    parameter int                       ADDR_W     = $clog2(DEPTH),
    parameter int                       WIDTH      = 10,
    parameter logic [DEPTH*WIDTH-1:0]   INIT_IMAGE = '1
) (
    input  logic              i_clk,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    logic [WIDTH-1:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_rd_en) begin
            r_rd_data <= INIT_IMAGE[i_rd_addr*WIDTH +: WIDTH];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/lcd_init_sequencer.sv
// rtl/lcd_init_sequencer.sv - plays a tagged LCD init script out as a valid/ready byte stream
// Ports:
//   i_clk        system clock
//   i_rst_n      asynchronous reset, active-low
//   i_start      pulse; starts playback from entry 0 (ignored unless idle)
//   o_out_valid  o_out_byte/o_out_dc hold a byte for the SPI TX
//   i_out_ready  SPI TX accepts the byte when o_out_valid && i_out_ready
//   o_out_byte   command or parameter byte
//   o_out_dc     0 = command, 1 = data
//   o_busy       script in progress
//   o_done       one-cycle pulse, END entry reached
//   o_err        one-cycle pulse, last entry consumed without END
module lcd_init_sequencer
    import lcd_seq_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int DEPTH         = 64,
    parameter int ADDR_W        = $clog2(DEPTH),
    parameter int CLK_HZ        = 12_000_000,
    parameter int DELAY_UNIT_US = 1000,
    parameter logic [DEPTH*(DATA_W+2)-1:0] INIT_IMAGE = '1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_byte,
    output logic              o_out_dc,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    localparam int ENTRY_W = entry_w(DATA_W);
    localparam int TICKS   = CLK_HZ / 1_000_000 * DELAY_UNIT_US;
    localparam int PRE_W   = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICKS - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    seq_state_t        r_state, w_state;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic              r_out_valid, w_out_valid;
    logic [DATA_W-1:0] r_out_byte, w_out_byte;
    logic              r_out_dc, w_out_dc;
    logic              r_busy, w_busy;
    logic              r_done, w_done;
    logic              r_err, w_err;
    logic [DATA_W-1:0] r_unit, w_unit;
    logic [PRE_W-1:0]  r_presc, w_presc;

    logic               w_rd_en;
    logic               w_advance;
    logic [ENTRY_W-1:0] w_rd_data;
    logic [1:0]         w_tag;
    logic [DATA_W-1:0]  w_payload;

    seq_rom #(
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W),
        .WIDTH      (ENTRY_W),
        .INIT_IMAGE (INIT_IMAGE)
    ) u_rom (
        .i_clk     (i_clk),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_addr),
        .o_rd_data (w_rd_data)
    );

    assign w_tag     = w_rd_data[ENTRY_W-1 -: 2];
    assign w_payload = w_rd_data[DATA_W-1:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_out_valid <= 1'b0;
            r_out_byte  <= '0;
            r_out_dc    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_unit      <= '0;
            r_presc     <= '0;
        end else begin
            r_state     <= w_state;
            r_addr      <= w_addr;
            r_out_valid <= w_out_valid;
            r_out_byte  <= w_out_byte;
            r_out_dc    <= w_out_dc;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_err       <= w_err;
            r_unit      <= w_unit;
            r_presc     <= w_presc;
        end
    end

    // done/err are raised on entry to FINISH, so during the pulse the FSM is
    // still in FINISH and a coincident start is not accepted.
    always_comb begin
        w_state     = r_state;
        w_addr      = r_addr;
        w_out_valid = r_out_valid;
        w_out_byte  = r_out_byte;
        w_out_dc    = r_out_dc;
        w_busy      = r_busy;
        w_done      = 1'b0;
        w_err       = 1'b0;
        w_unit      = r_unit;
        w_presc     = r_presc;
        w_rd_en     = (r_state == S_FETCH);
        w_advance   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_addr  = '0;
                    w_busy  = 1'b1;
                    w_state = S_FETCH;
                end
            end
            S_FETCH: begin
                w_state = S_DECODE;
            end
            S_DECODE: begin
                case (w_tag)
                    TAG_CMD, TAG_DATA: begin
                        w_out_byte  = w_payload;
                        w_out_dc    = (w_tag == TAG_DATA);
                        w_out_valid = 1'b1;
                        w_state     = S_SEND;
                    end
                    TAG_DELAY: begin
                        if (w_payload != '0) begin
                            w_unit  = w_payload;
                            w_presc = '0;
                            w_state = S_WAIT;
                        end else begin
                            w_advance = 1'b1;
                        end
                    end
                    default: begin
                        w_done  = 1'b1;
                        w_busy  = 1'b0;
                        w_state = S_FINISH;
                    end
                endcase
            end
            S_SEND: begin
                if (i_out_ready) begin
                    w_out_valid = 1'b0;
                    w_advance   = 1'b1;
                end
            end
            S_WAIT: begin
                if (r_presc == PRE_LAST) begin
                    w_presc = '0;
                    w_unit  = r_unit - DATA_W'(1);
                    if (r_unit == DATA_W'(1)) begin
                        w_advance = 1'b1;
                    end
                end else begin
                    w_presc = r_presc + PRE_W'(1);
                end
            end
            S_FINISH: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        if (w_advance) begin
            if (r_addr == ADDR_LAST) begin
                w_err   = 1'b1;
                w_busy  = 1'b0;
                w_state = S_FINISH;
            end else begin
                w_addr  = r_addr + ADDR_W'(1);
                w_state = S_FETCH;
            end
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_byte  = r_out_byte;
    assign o_out_dc    = r_out_dc;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_err       = r_err;

endmodule

// File: tb/tb_lcd_init_sequencer.sv
// tb/tb_lcd_init_sequencer.sv - directed self-checking bench for lcd_init_sequencer
module tb_lcd_init_sequencer;

    // Instance A: CMD 11, DELAY 2, CMD 29, END (1 us units at 12 MHz -> 12 cycles/unit)
    localparam logic [64*10-1:0] IMG_A = {{60{10'h3FF}}, 10'h3FF, 10'h029, 10'h202, 10'h011};
    // Instance B: CMD 2A, DATA 00, DATA 7F, END
    localparam logic [8*10-1:0]  IMG_B = {{4{10'h3FF}}, 10'h3FF, 10'h17F, 10'h100, 10'h02A};
    // Instance C: CMD 01, DELAY 0, CMD 02, END
    localparam logic [8*10-1:0]  IMG_C = {{4{10'h3FF}}, 10'h3FF, 10'h002, 10'h200, 10'h001};
    // Instance D: four CMD 00 entries, no END
    localparam logic [4*10-1:0]  IMG_D = '0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [3:0] start;
    logic [3:0] ready;
    wire  [3:0] valid, dc, busy, done, err;
    wire  [7:0] obyte [4];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int hs_cnt   [4] = '{default: 0};
    int done_cnt [4] = '{default: 0};
    int err_cnt  [4] = '{default: 0};
    logic [8:0] hs_log [4][16];
    int         hs_cyc [4][16];

    lcd_init_sequencer #(.DATA_W(8), .DEPTH(64), .CLK_HZ(12_000_000), .DELAY_UNIT_US(1), .INIT_IMAGE(IMG_A)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[0]), .o_out_valid(valid[0]), .i_out_ready(ready[0]),
        .o_out_byte(obyte[0]), .o_out_dc(dc[0]), .o_busy(busy[0]), .o_done(done[0]), .o_err(err[0]));
    lcd_init_sequencer #(.DATA_W(8), .DEPTH(8), .CLK_HZ(12_000_000), .DELAY_UNIT_US(1000), .INIT_IMAGE(IMG_B)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[1]), .o_out_valid(valid[1]), .i_out_ready(ready[1]),
        .o_out_byte(obyte[1]), .o_out_dc(dc[1]), .o_busy(busy[1]), .o_done(done[1]), .o_err(err[1]));
    lcd_init_sequencer #(.DATA_W(8), .DEPTH(8), .CLK_HZ(12_000_000), .DELAY_UNIT_US(1000), .INIT_IMAGE(IMG_C)) u_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[2]), .o_out_valid(valid[2]), .i_out_ready(ready[2]),
        .o_out_byte(obyte[2]), .o_out_dc(dc[2]), .o_busy(busy[2]), .o_done(done[2]), .o_err(err[2]));
    lcd_init_sequencer #(.DATA_W(8), .DEPTH(4), .CLK_HZ(12_000_000), .DELAY_UNIT_US(1000), .INIT_IMAGE(IMG_D)) u_d (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[3]), .o_out_valid(valid[3]), .i_out_ready(ready[3]),
        .o_out_byte(obyte[3]), .o_out_dc(dc[3]), .o_busy(busy[3]), .o_done(done[3]), .o_err(err[3]));

    // Handshake / pulse monitor
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 4; k++) begin
            if (valid[k] && ready[k]) begin
                hs_log[k][hs_cnt[k] % 16] <= {dc[k], obyte[k]};
                hs_cyc[k][hs_cnt[k] % 16] <= cyc;
                hs_cnt[k] <= hs_cnt[k] + 1;
            end
            if (done[k]) done_cnt[k] <= done_cnt[k] + 1;
            if (err[k])  err_cnt[k]  <= err_cnt[k] + 1;
        end
    end

    typedef struct {
        int         inst;
        int         stall;
        logic [7:0] b;
        logic       dc;
    } vec_t;

    vec_t tv [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic pulse_start(input int k);
        @(negedge clk);
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Applies table records [first, first+n): waits for the byte, stalls ready,
    // checks stability while stalled, then completes one handshake.
    task automatic play(input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            int k;
            int w;
            k = tv[i].inst;
            w = 0;
            while (!valid[k] && w < 200) begin
                @(negedge clk);
                w++;
            end
            chk($sformatf("vec%0d_valid", i), {31'd0, valid[k]}, 32'd1);
            for (int s = 0; s < tv[i].stall; s++) begin
                chk($sformatf("vec%0d_stall%0d", i, s), {22'd0, valid[k], dc[k], obyte[k]}, {22'd0, 1'b1, tv[i].dc, tv[i].b});
                @(negedge clk);
            end
            chk($sformatf("vec%0d_byte", i), {23'd0, dc[k], obyte[k]}, {23'd0, tv[i].dc, tv[i].b});
            ready[k] = 1'b1;
            @(negedge clk);
            ready[k] = 1'b0;
        end
    endtask

    task automatic wait_done(input int k, input int base, input int limit);
        int w;
        w = 0;
        while (done_cnt[k] == base && w < limit) begin
            @(negedge clk);
            w++;
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, d0, e0, w;

        tv[0] = '{0, 0, 8'h11, 1'b0};
        tv[1] = '{0, 0, 8'h29, 1'b0};
        tv[2] = '{1, 5, 8'h2A, 1'b0};
        tv[3] = '{1, 5, 8'h00, 1'b1};
        tv[4] = '{1, 5, 8'h7F, 1'b1};
        tv[5] = '{2, 0, 8'h01, 1'b0};
        tv[6] = '{2, 0, 8'h02, 1'b0};

        rst_n = 1'b0;
        start = '0;
        ready = '0;
        idle(3);
        rst_n = 1'b1;
        idle(2);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("reset_outputs%0d", k), {19'd0, valid[k], dc[k], busy[k], done[k], err[k], obyte[k]}, 32'd0);
        end

        // 1: delay between two commands
        b0 = hs_cnt[0]; d0 = done_cnt[0];
        pulse_start(0);
        chk("a_busy_after_start", {31'd0, busy[0]}, 32'd1);
        play(0, 2);
        wait_done(0, d0, 50);
        idle(3);
        chk("a_done_count", done_cnt[0] - d0, 32'd1);
        chk("a_busy_end", {31'd0, busy[0]}, 32'd0);
        chk("a_err_none", err_cnt[0], 32'd0);
        chk_range("a_delay_gap", hs_cyc[0][(b0+1)%16] - hs_cyc[0][b0%16], 24, 30);

        // 2: stalled ready, DATA entries
        b0 = hs_cnt[1]; d0 = done_cnt[1];
        pulse_start(1);
        play(2, 3);
        wait_done(1, d0, 50);
        idle(3);
        chk("b_handshakes", hs_cnt[1] - b0, 32'd3);
        chk("b_done_count", done_cnt[1] - d0, 32'd1);

        // 6: DELAY 0 never enters a wait state
        b0 = hs_cnt[2]; d0 = done_cnt[2];
        pulse_start(2);
        play(5, 2);
        wait_done(2, d0, 50);
        idle(3);
        chk_range("c_delay0_gap", hs_cyc[2][(b0+1)%16] - hs_cyc[2][b0%16], 3, 5);
        chk("c_done_count", done_cnt[2] - d0, 32'd1);

        // 3: no END entry in the ROM
        b0 = hs_cnt[3]; e0 = err_cnt[3]; d0 = done_cnt[3];
        ready[3] = 1'b1;
        pulse_start(3);
        w = 1;
        while (!valid[3] && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk_range("d_first_valid_latency", w, 2, 3);
        w = 0;
        while (!err[3] && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("d_err_seen", {31'd0, err[3]}, 32'd1);
        chk("d_busy_at_err", {31'd0, busy[3]}, 32'd0);
        @(negedge clk);
        chk("d_err_one_cycle", {31'd0, err[3]}, 32'd0);
        idle(5);
        ready[3] = 1'b0;
        chk("d_handshakes", hs_cnt[3] - b0, 32'd4);
        chk("d_err_count", err_cnt[3] - e0, 32'd1);
        chk("d_done_never", done_cnt[3] - d0, 32'd0);
        for (int i = 1; i < 4; i++) begin
            chk($sformatf("d_gap%0d", i), hs_cyc[3][(b0+i)%16] - hs_cyc[3][(b0+i-1)%16], 32'd3);
            chk($sformatf("d_byte%0d", i), {23'd0, hs_log[3][(b0+i)%16]}, 32'd0);
        end

        // 4: start mid-script and on the done cycle are ignored
        b0 = hs_cnt[0]; d0 = done_cnt[0];
        ready[0] = 1'b1;
        pulse_start(0);
        idle(10);
        pulse_start(0);
        chk("a_busy_mid", {31'd0, busy[0]}, 32'd1);
        w = 0;
        while (!done[0] && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("a_done_seen", {31'd0, done[0]}, 32'd1);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        idle(40);
        chk("a_restart_handshakes", hs_cnt[0] - b0, 32'd2);
        chk("a_restart_done", done_cnt[0] - d0, 32'd1);
        chk("a_no_restart_busy", {31'd0, busy[0]}, 32'd0);
        chk("a_restart_byte0", {23'd0, hs_log[0][b0%16]}, 32'h011);
        chk("a_restart_byte1", {23'd0, hs_log[0][(b0+1)%16]}, 32'h029);
        ready[0] = 1'b0;

        // 5: reset during SEND and during WAIT, then replay
        b0 = hs_cnt[0];
        pulse_start(0);
        w = 0;
        while (!valid[0] && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("a_send_valid", {31'd0, valid[0]}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("a_reset_in_send", {19'd0, valid[0], dc[0], busy[0], done[0], err[0], obyte[0]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("a_reset_no_handshake", hs_cnt[0] - b0, 32'd0);

        ready[0] = 1'b1;
        pulse_start(0);
        w = 0;
        while (hs_cnt[0] == b0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        idle(5);
        chk("a_wait_state", {30'd0, busy[0], valid[0]}, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("a_reset_in_wait", {19'd0, valid[0], dc[0], busy[0], done[0], err[0], obyte[0]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        b0 = hs_cnt[0]; d0 = done_cnt[0];
        pulse_start(0);
        wait_done(0, d0, 100);
        idle(3);
        ready[0] = 1'b0;
        chk("a_replay_handshakes", hs_cnt[0] - b0, 32'd2);
        chk("a_replay_byte0", {23'd0, hs_log[0][b0%16]}, 32'h011);
        chk("a_replay_byte1", {23'd0, hs_log[0][(b0+1)%16]}, 32'h029);
        chk("a_replay_done", done_cnt[0] - d0, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
